writeback_unit: RTL and testbench

- Writeback stage sitting directly upstream of the register file write port.
- Accepts register results from the execute/memory stage over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drives the register file's single-pulse write request and waits for its write_done before retiring each entry.
- Publishes a pending-destination mask so decode can stall on RAW hazards against results not yet written.

---
 rtl/writeback_unit.sv | 125 ++++++++++++
 tb/tb_writeback_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Writeback stage: buffers execute results in an in-order FIFO and drains them one at a time
// into the register file write port, publishing a RAW-hazard mask of pending destinations.
module writeback_unit #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [63:0] in_value,
  output logic        rf_write_enable,
  output logic [4:0]  rf_write_register,
  output logic [63:0] rf_write_value,
  input  logic        rf_write_done,
  output logic [31:0] pending_mask,
  output logic        idle,
  output logic        timeout_error,
  output logic [31:0] retired_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e          r_state, w_state_next;
  logic [4:0]      r_mem_rd  [DEPTH];
  logic [63:0]     r_mem_val [DEPTH];
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic [TmoW-1:0] r_tmo, w_tmo_next, w_tmo_inc;
  logic            r_terr;
  logic [31:0]     r_retired;
  logic            w_push, w_pop, w_done_pop, w_tmo_pop, w_busy;

  assign in_ready  = (r_count != CntW'(DEPTH));
  // Writes to x0 are architecturally void, so they are swallowed at the input.
  assign w_push    = in_valid && in_ready && (in_rd != 5'd0);
  assign w_pop     = w_done_pop || w_tmo_pop;
  assign w_tmo_inc = r_tmo + TmoW'(1);

  always_comb begin
    w_state_next    = r_state;
    w_tmo_next      = r_tmo;
    w_done_pop      = 1'b0;
    w_tmo_pop       = 1'b0;
    rf_write_enable = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_count != '0) w_state_next = StIssue;
      end
      StIssue: begin
        rf_write_enable = 1'b1;
        w_tmo_next      = '0;
        w_state_next    = StWait;
      end
      StWait: begin
        if (rf_write_done) begin
          w_done_pop   = 1'b1;
          w_tmo_next   = '0;
          w_state_next = (r_count > CntW'(1)) ? StIssue : StIdle;
        end else if (w_tmo_inc == TmoW'(TIMEOUT_CYCLES)) begin
          w_tmo_pop    = 1'b1;
          w_tmo_next   = '0;
          w_state_next = (r_count > CntW'(1)) ? StIssue : StIdle;
        end else begin
          w_tmo_next = w_tmo_inc;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_tmo     <= '0;
      r_terr    <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_next;
      r_tmo   <= w_tmo_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CntW'(1);
      end
      if (w_tmo_pop)  r_terr    <= 1'b1;
      if (w_done_pop) r_retired <= r_retired + 32'd1;
    end
  end

  // Payload storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr]  <= in_rd;
      r_mem_val[r_wr_ptr] <= in_value;
    end
  end

  // Head is only popped from WAIT, so it stays stable from request until done.
  assign w_busy            = (r_state != StIdle);
  assign rf_write_register = w_busy ? r_mem_rd[r_rd_ptr]  : 5'd0;
  assign rf_write_value    = w_busy ? r_mem_val[r_rd_ptr] : 64'd0;

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CntW'(i) < r_count) pending_mask[r_mem_rd[r_rd_ptr + PtrW'(i)]] = 1'b1;
    end
  end

  assign idle          = (r_count == '0) && (r_state == StIdle);
  assign timeout_error = r_terr;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized scoreboard bench for writeback_unit: a transaction-level model of the buffered
// results predicts issue timing, write data, retire/drop outcomes, hazard mask and status.
module tb_writeback_unit;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] val;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic [63:0] in_value = '0;
  logic        rf_write_enable;
  logic [4:0]  rf_write_register;
  logic [63:0] rf_write_value;
  logic        rf_write_done;
  logic [31:0] pending_mask;
  logic        idle;
  logic        timeout_error;
  logic [31:0] retired_count;

  logic        done_auto = 1'b0;
  logic        done_force = 1'b0;
  int unsigned rf_delay = 2;
  int          rsp_cnt = 0;

  ent_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;

  assign rf_write_done = done_auto | done_force;

  writeback_unit #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_rd             (in_rd),
    .in_value          (in_value),
    .rf_write_enable   (rf_write_enable),
    .rf_write_register (rf_write_register),
    .rf_write_value    (rf_write_value),
    .rf_write_done     (rf_write_done),
    .pending_mask      (pending_mask),
    .idle              (idle),
    .timeout_error     (timeout_error),
    .retired_count     (retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register-file responder: pulses done rf_delay cycles after a request (0 = never answers).
  always @(negedge clk) begin
    done_auto = 1'b0;
    if (!reset) begin
      rsp_cnt = 0;
    end else begin
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) done_auto = 1'b1;
      end
      if (rf_write_enable && rf_delay != 0) rsp_cnt = int'(rf_delay);
    end
  end

  // ---------------- monitor / reference model ----------------
  bit          infl = 0;
  ent_t        infl_e;
  int          w_cnt = 0;
  int unsigned exp_ret = 0;
  bit          exp_terr = 0;
  int          cyc = 0;
  longint      exp_issue = -1;
  int          sz_prev = 0;
  bit          prev_en = 0;
  bit          s_en, s_done, ended;
  logic [4:0]  s_rd;
  logic [63:0] s_val;
  ent_t        head;
  int          outst;
  logic [31:0] exp_mask;

  always begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      #1;
      chk("rst_enable", rf_write_enable, 0);
      chk("rst_register", rf_write_register, 0);
      chk("rst_value", rf_write_value, 0);
      chk("rst_mask", pending_mask, 0);
      chk("rst_idle", idle, 1);
      chk("rst_timeout_error", timeout_error, 0);
      chk("rst_retired", retired_count, 0);
      chk("rst_in_ready", in_ready, 1);
      exp_q.delete();
      infl = 0; w_cnt = 0; exp_ret = 0; exp_terr = 0; exp_issue = -1; sz_prev = 0; prev_en = 0;
    end else begin
      s_en = rf_write_enable; s_done = rf_write_done;
      s_rd = rf_write_register; s_val = rf_write_value;
      cyc++;
      #1;
      ended = 0;
      if (infl) begin
        w_cnt++;
        if (s_done) begin
          exp_ret++; infl = 0; ended = 1;
        end else if (w_cnt == TMO) begin
          exp_terr = 1; infl = 0; ended = 1;
        end
        if (ended && sz_prev > 0) exp_issue = cyc + 1;
      end
      if (s_en) begin
        chk("enable_consecutive", prev_en, 0);
        chk("issue_cycle", cyc, exp_issue);
        if (sz_prev == 0) begin
          chk("issue_unexpected", s_en, 0);
        end else begin
          head = exp_q.pop_front();
          chk("issue_register", s_rd, head.rd);
          chk("issue_value", s_val, head.val);
          infl = 1; infl_e = head; w_cnt = 0;
        end
        exp_issue = -1;
      end else if (cyc == exp_issue) begin
        chk("issue_missing", s_en, 1);
        exp_issue = -1;
      end
      // A result landing in an empty, quiet unit issues two edges after its accept edge.
      if (exp_q.size() > sz_prev && sz_prev == 0 && !infl && exp_issue < 0 && !s_en)
        exp_issue = cyc + 2;
      sz_prev = exp_q.size();
      prev_en = s_en;

      outst = exp_q.size() + (infl ? 1 : 0);
      exp_mask = '0;
      foreach (exp_q[i]) exp_mask[exp_q[i].rd] = 1'b1;
      if (infl) exp_mask[infl_e.rd] = 1'b1;
      chk("in_ready", in_ready, (outst < DEPTH) ? 1 : 0);
      chk("idle", idle, (outst == 0) ? 1 : 0);
      chk("pending_mask", pending_mask, exp_mask);
      chk("retired_count", retired_count, exp_ret);
      chk("timeout_error", timeout_error, exp_terr);
      if (infl) begin
        chk("hold_register", rf_write_register, infl_e.rd);
        chk("hold_value", rf_write_value, infl_e.val);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [4:0] rd, input logic [63:0] val, input logic spur);
    int   k;
    ent_t e;
    k = 0;
    @(negedge clk);
    in_valid = 1'b1; in_rd = rd; in_value = val; done_force = spur;
    forever begin
      @(posedge clk);
      if (in_ready) break;
      k++;
      if (k > 300) begin
        n_tests++; n_fail++;
        $display("FAIL accept_timeout: in_ready stuck 0 for rd %0d", rd);
        break;
      end
    end
    if (k <= 300 && rd != 5'd0) begin
      e.rd = rd; e.val = val;
      exp_q.push_back(e);
    end
  endtask

  task automatic gap(input int n);
    @(negedge clk);
    in_valid = 1'b0; done_force = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic wait_idle(input int bound);
    int k;
    gap(1);
    for (k = 0; k < bound; k++) begin
      @(negedge clk);
      if (idle) break;
    end
    if (k >= bound) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: idle=%0d required 1", idle);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;

    rf_delay = 2;
    send(5'd5, 64'h1234, 1'b0);
    wait_idle(100);

    send(5'd0, 64'hFFFF, 1'b0);
    wait_idle(20);

    rf_delay = 12;
    for (int i = 1; i <= 5; i++) send(5'(i), 64'hA0 + 64'(i), 1'b0);
    wait_idle(300);

    rf_delay = 0;
    send(5'd7, 64'h77, 1'b0);
    gap(4);
    rf_delay = 2;
    send(5'd8, 64'h88, 1'b0);
    wait_idle(200);

    rf_delay = 0;
    send(5'd3, 64'h33, 1'b0);
    send(5'd4, 64'h44, 1'b0);
    send(5'd6, 64'h66, 1'b0);
    gap(4);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    done_force = 1'b1;
    @(negedge clk);
    done_force = 1'b0;
    rf_delay = 2;
    repeat (3) @(negedge clk);

    for (int n = 0; n < 300; n++) begin
      rf_delay = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
      send(5'($urandom_range(0, 31)), {$urandom, $urandom}, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 6));
    end
    wait_idle(600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
